// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: frame sequencer for the sobel core.
// It turns a raster pixel stream into 3x3 windows using two line buffers and
// hands each interior window to the core. Core results come back into a
// small output FIFO, and the FIFO drives a valid/ready result stream.
// Optional perforation: odd windows in a row skip the core and repeat the
// last emitted value.
module sobel_window_ctrl #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int CORE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        perf_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pix,
  output logic [71:0] core_win,
  input  logic [7:0]  core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pix,
  output logic        busy,
  output logic        done
);

  localparam int DEPTH = CORE_LAT + 2;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int NW    = $clog2(DEPTH + 1);
  localparam int TW    = $clog2(CORE_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e        state_q;
  logic          perf_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb2_q [IMG_W];
  logic [7:0]    win_q [9];
  logic [71:0]   win_d;
  logic [CORE_LAT:0] tag_vld_q;
  logic [CORE_LAT:0] tag_rep_q;
  logic [7:0]    last_q;
  logic [7:0]    fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [NW-1:0] cnt_q;

  logic          accept;
  logic          last_pix;
  logic          issue;
  logic          capture;
  logic [7:0]    cap_val;
  logic          pop;
  logic [TW-1:0] tags;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
  assign issue    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign capture  = tag_vld_q[CORE_LAT];
  assign cap_val  = tag_rep_q[CORE_LAT] ? last_q : core_out;
  assign pop      = out_valid && out_ready;

  assign out_valid = (cnt_q != '0);
  assign out_pix   = fifo_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Count tags in flight and admit a pixel only while the FIFO has room for every one of them.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
    tags = '0;
    for (int i = 0; i <= CORE_LAT; i++) tags = tags + TW'(tag_vld_q[i]);
    in_ready = (state_q == RUN) && ((int'(cnt_q) + int'(tags) + 1) <= DEPTH);
  end

  // Next window: shift every row left by one and add the new column (r-2, r-1, r) on the right.
  always_comb begin
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[8*(3*r)   +: 8] = win_q[3*r+1];
      win_d[8*(3*r+1) +: 8] = win_q[3*r+2];
    end
    win_d[8*2 +: 8] = lb2_q[col_q];
    win_d[8*5 +: 8] = lb1_q[col_q];
    win_d[8*8 +: 8] = in_pix;
  end

  // Frame FSM: IDLE -> RUN -> FLUSH -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      perf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          perf_q  <= perf_en;
        end
        RUN:   if (accept && last_pix) state_q <= FLUSH;
        FLUSH: if (pop && cnt_q == NW'(1) && tags == '0) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == IDLE && start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Line buffers and the 3x3 shift window advance on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these storage arrays are cleared by reset so that a restarted frame never sees stale data.
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else if (accept) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_pix;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[8*k +: 8];
    end
  end

  // Registered core window plus the tag pipe that tracks the core latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_win  <= '0;
      tag_vld_q <= '0;
      tag_rep_q <= '0;
    end else begin
      if (issue) core_win <= win_d;
      tag_vld_q <= {tag_vld_q[CORE_LAT-1:0], issue};
      tag_rep_q <= {tag_rep_q[CORE_LAT-1:0], issue && perf_q && col_q[0]};
    end
  end

  // Last value written to the FIFO. Repeat windows re-emit this value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        last_q <= '0;
    else if (state_q == IDLE && start) last_q <= '0;
    else if (capture)                  last_q <= cap_val;
  end

  // First-word fall-through result FIFO. Push and pop in the same cycle keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (capture) begin
        fifo_q[wr_ptr_q] <= cap_val;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (capture && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!capture && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: a 6x4 frame with a 3-deep core model.
// A table of frame scenarios drives the run. Expected results are queued when
// each window pixel is accepted and are compared as results leave.
module tb_sobel_window_ctrl;

  localparam int W    = 6;
  localparam int H    = 4;
  localparam int LAT  = 3;
  localparam int D    = LAT + 2;
  localparam int NRES = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        perf_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_pix = '0;
  logic        in_ready, out_valid, busy, done;
  logic [7:0]  core_out, out_pix;
  logic [71:0] core_win;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] img [H][W];
  logic [7:0] sb [$];
  logic [7:0] core_pipe [LAT];

  typedef struct {
    bit perf;      // perf_en at start
    bit rnd;       // random in_valid / out_ready gaps
    int stall_at;  // accepted-pixel count that begins a 30-cycle out_ready stall (0 = none)
    bit mid_start; // pulse start and flip perf_en mid-frame
    int seed;      // 0 = raster ramp image, else random image
    int n_res;     // results expected
    int n_done;    // done cycles expected
  } frame_cfg_t;

  frame_cfg_t tbl [6];

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .perf_en(perf_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .core_win(core_win), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] core_fn(input logic [71:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 9; k++) acc = acc + w[8*k +: 8] * 8'(k + 1);
    return acc ^ 8'h5a;
  endfunction

  // Core model: LAT register stages from core_win to core_out.
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_win);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  function automatic logic [71:0] win_at(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[8*(3*dr+dc) +: 8] = img[r-2+dr][c-2+dc];
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_img(input int seed);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (seed == 0) ? 8'(r * W + c) : 8'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input frame_cfg_t cfg);
    int sent = 0, got = 0, cyc = 0, dones = 0, post = 0;
    int stall_left = 0, rdy_bad = 0, flush_rdy = 0, max_out = 0;
    int last_pop_cyc = -1, done_cyc = -1;
    bit stalled = 0, mid_done = 0, win_chk = 0, first_win = 1;
    logic [71:0] exp_win = '0;
    logic [7:0] last_exp = 8'h00;
    logic [7:0] e;
    bit exp_rdy;
    fill_img(cfg.seed);
    sb.delete();
    @(negedge clk);
    start = 1'b1; perf_en = cfg.perf;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 3000 && !(dones > 0 && post >= 3)) begin
      // Drive this cycle's inputs.
      in_valid  = (sent < W*H) && (!cfg.rnd || $urandom_range(0, 3) != 0);
      in_pix    = (sent < W*H) ? img[sent / W][sent % W] : 8'h00;
      out_ready = (stall_left == 0) && (!cfg.rnd || $urandom_range(0, 2) != 0);
      if (cfg.mid_start && !mid_done && sent >= 10) begin
        start = 1'b1; perf_en = ~cfg.perf; mid_done = 1;
      end else begin
        start = 1'b0;
      end
      #1;
      // Sample settled outputs. These describe the handshakes at the next rising edge.
      if (win_chk) begin
        check("first_core_win", core_win, exp_win);
        win_chk = 0;
      end
      exp_rdy = (sent < W*H) && (sb.size() + 1 <= D);
      if (in_ready !== exp_rdy) rdy_bad++;
      if (sent == W*H && in_ready) flush_rdy++;
      if (stall_left == 1) begin
        check("stall_in_ready_low", in_ready, 0);
        check("stall_outstanding", sb.size(), D);
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dones > 0) post++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", out_pix, 0);
          n_err++;
          $display("FAIL extra_result: got %0h expected none", out_pix);
        end else begin
          e = sb.pop_front();
          check("result", out_pix, e);
        end
        got++;
        last_pop_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (sent / W >= 2 && sent % W >= 2) begin
          if (cfg.perf && ((sent % W - 2) % 2 == 1)) e = last_exp;
          else e = core_fn(win_at(sent / W, sent % W));
          last_exp = e;
          sb.push_back(e);
          if (sb.size() > max_out) max_out = sb.size();
          if (first_win) begin
            exp_win = win_at(sent / W, sent % W);
            win_chk = 1; first_win = 0;
          end
        end
        sent++;
      end
      if (stall_left > 0) stall_left--;
      if (cfg.stall_at > 0 && !stalled && sent == cfg.stall_at) begin
        stall_left = 30; stalled = 1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    check("frame_timeout", (cyc >= 3000), 0);
    check("results_count", got, cfg.n_res);
    check("sb_empty", sb.size(), 0);
    check("done_cycles", dones, cfg.n_done);
    check("done_after_last", done_cyc - last_pop_cyc, 1);
    check("in_ready_model", rdy_bad, 0);
    check("in_ready_flush", flush_rdy, 0);
    check("outstanding_max", (max_out <= D), 1);
    check("busy_after", busy, 0);
  endtask

  task automatic reset_mid_frame();
    int sent = 0, ab_done = 0;
    fill_img(0);
    @(negedge clk);
    start = 1'b1; perf_en = 1'b0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 60 && sent < 16; i++) begin
      in_valid = 1'b1; in_pix = img[sent / W][sent % W];
      #1;
      if (in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("pre_reset_out_valid", out_valid, 1);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_core_win", core_win, 0);
    check("rst_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) ab_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) ab_done++;
    end
    check("aborted_no_done", ab_done, 0);
  endtask

  initial begin
    //        perf rnd stall mid seed nres  ndone
    tbl[0] = '{0,   0,  0,    0,  0,   NRES, 1};
    tbl[1] = '{1,   0,  0,    0,  0,   NRES, 1};
    tbl[2] = '{0,   0,  8,    0,  7,   NRES, 1};
    tbl[3] = '{0,   1,  0,    0,  3,   NRES, 1};
    tbl[4] = '{0,   0,  0,    1,  4,   NRES, 1};
    tbl[5] = '{1,   1,  0,    1,  5,   NRES, 1};

    #12;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_pix", out_pix, 0);
    check("reset_core_win", core_win, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    reset_mid_frame();
    run_frame(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Frame-level sequencer for the sobel core. Accepts a raster-order 8-bit grayscale stream and builds 3x3 neighbourhoods with two line buffers. Presents each interior window to the core and collects the core result after its fixed latency. Emits one result per interior pixel with valid/ready flow control. Optionally applies loop perforation: every second window in a row skips the core and repeats the previously emitted value.

Parameters:
IMG_W, 512, frame width in pixels (>=3)
IMG_H, 512, frame height in pixels (>=3)
CORE_LAT, 1, clocks from core_win change to matching core_out (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame (honoured only in IDLE)
perf_en  in  1  loop-perforation enable, sampled on accepted start
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid&&in_ready
in_pix  in  8  input pixel, raster order
core_win  out  72  window to core; bits [8k+7:8k]=pk, p0 top-left .. p8 bottom-right, raster order
core_out  in  8  core result
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_pix  out  8  result
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last result handshake

Behaviour:
- Reset: all outputs 0. FSM=IDLE. Counters, line buffers, window regs, tag pipe and FIFO cleared. Applies mid-frame too; the partial frame is discarded and no done is issued.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE->RUN on start; latch perf_en. start in any other state is ignored.
- RUN->FLUSH when pixel IMG_W*IMG_H-1 is accepted.
- FLUSH->DONE when the last result handshakes (FIFO and tag pipe empty, all outputs emitted).
- DONE asserts done for one cycle, then ->IDLE.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1, updated per accepted pixel. col wraps to 0 and row increments at col==IMG_W-1.
- Line buffers: two IMG_W-deep, indexed by col, giving rows r-1 and r-2. The 3x3 shift window shifts in {lb2[col], lb1[col], in_pix} on each accept.
- Window issue: when the accepted pixel has row>=2 and col>=2, the window centred at (row-1,col-1) is issued. core_win is registered, so it updates the cycle after the accept. A tag bit enters a CORE_LAT-deep shift pipe.
- core_win holds its value when no window is issued.
- Capture: when the tag exits the pipe, core_out is written to the output FIFO.
- Perforation (perf_en latched): wcol = col-2 is the window index within the row.
  - Odd wcol: the tag is marked "repeat"; at exit, the last FIFO-written value is written instead of core_out.
  - wcol 0 of every row is always computed.
  - Repeat windows still drive core_win.
- Output FIFO: depth CORE_LAT+2. out_valid = FIFO non-empty; out_pix = FIFO head (first-word fall-through).
- in_ready = (state==RUN) && (fifo_count + tags_in_flight + 1 <= CORE_LAT+2). This guarantees the non-stallable core never overflows the FIFO. in_ready is 0 in IDLE, FLUSH and DONE.
- Total results per frame: exactly (IMG_W-2)*(IMG_H-2). Border pixels produce nothing.
- Same-cycle FIFO push and pop: occupancy unchanged, order preserved.
- last-value register resets to 0 per frame.

Test Plan:
1. IMG_W=4, IMG_H=4, CORE_LAT=1, pixels 0..15 streamed, out_ready=1 -> first core_win = p0..p8 = 0,1,2,4,5,6,8,9,10. Exactly 4 results equal to reference-model core outputs in raster order; done pulses once after the 4th; busy low afterward.
2. IMG_W=6, IMG_H=3, perf_en=1, core model out=p4 -> outputs 7,7,9,9: windows 1 and 3 repeat windows 0 and 2.
3. Test 1 with out_ready=0 for 30 cycles mid-frame -> in_ready drops once FIFO occupancy plus in-flight tags reaches CORE_LAT+2; no result lost or duplicated; in_ready never high in FLUSH; order correct after release.
4. CORE_LAT=3, random in_valid/out_ready gaps, 8x8 frame -> 36 results match model; FIFO never overflows (assertion).
5. rst_n low during pixel 9 of test 1, then restart -> all outputs 0 during reset; no done for aborted frame; next frame yields the correct 4 results.
6. start pulsed during RUN -> ignored; frame completes with a single done; perf_en change mid-frame has no effect.
